// File: rtl/wb_cmd_master.sv
// wb_cmd_master
//   Wishbone classic master. Turns single read/write commands from a local
//   requester into one bus cycle each and returns the result on a
//   valid/ready response port. One transaction is outstanding at a time.
//
//   Optional feature macro: WB_TIMEOUT_EN
//     defined   - a cycle that sees no ack for TIMEOUT_CYC cycles is aborted
//                 with rsp_err_o = 1 and rsp_rdata_o = 32'hDEAD_BEEF.
//     undefined - the bus waits for ack forever; rsp_err_o is always 0.
//
//   Ports
//     wb_clk_i, wb_rst_n_i        clock, async active-low reset
//     cmd_valid_i / cmd_ready_o   command handshake (ready only in IDLE)
//     cmd_we_i, cmd_sel_i,
//     cmd_addr_i, cmd_wdata_i     command fields (addr is an offset to BASE_ADDR)
//     rsp_valid_o / rsp_ready_i   response handshake
//     rsp_rdata_o, rsp_err_o      read data (0 for writes), timeout flag
//     wbm_*                       Wishbone master signals
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for a command; cmd_ready_o = 1
//   BUS   | first cycle drives address/data only, then cyc/stb until ack
//   RSP   | response registered; rsp_valid_o rises one cycle after entry
//         | and is held until rsp_ready_i
//
//   Timing with a zero-wait slave: accept edge E0, cyc/stb high E1..E2,
//   ack sampled at E2, rsp_valid_o high from E3.

module wb_cmd_master #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [3:0]  cmd_sel_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
    // Count of no-ack cyc cycles already seen; the abort happens on the edge
    // that would make it TIMEOUT_CYC, so cyc is high exactly TIMEOUT_CYC cycles.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef WB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    we_d    = cmd_we_i;
                    sel_d   = cmd_sel_i;
                    adr_d   = BASE_ADDR | cmd_addr_i;
                    dat_d   = cmd_wdata_i;
                    state_d = ST_BUS;
`ifdef WB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_BUS: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                end else if (wbm_ack_i) begin
                    // ack takes priority over a coincident timeout
                    cyc_d       = 1'b0;
                    rsp_rdata_d = we_q ? 32'h0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_RSP;
                end else begin
`ifdef WB_TIMEOUT_EN
                    if (cnt_q == TO_LAST) begin
                        cyc_d       = 1'b0;
                        rsp_rdata_d = 32'hDEAD_BEEF;
                        rsp_err_d   = 1'b1;
                        state_d     = ST_RSP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            ST_RSP: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                end else if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
            adr_q       <= 32'h0;
            dat_q       <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
`ifdef WB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef WB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Testbench for wb_cmd_master: behavioural Wishbone slave with programmable
// wait states, response scoreboard checked at each response handshake.
module tb_wb_cmd_master;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [3:0]  cmd_sel = 4'h0;
    logic [31:0] cmd_addr = 32'h0;
    logic [31:0] cmd_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        wbm_cyc, wbm_stb, wbm_we, wbm_ack;
    logic [3:0]  wbm_sel;
    logic [31:0] wbm_adr, wbm_dat_o, wbm_dat_i;

    int          ack_wait = 0;
    logic        no_ack = 1'b0;
    logic        force_ack = 1'b0;
    logic [31:0] slave_rdata = 32'h0;
    int          stb_cnt = 0;

    int n_vec = 0;
    int n_miss = 0;
    logic [32:0] exp_q[$];

    wb_cmd_master #(.BASE_ADDR(BASE), .TIMEOUT_CYC(16)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_we_i(cmd_we), .cmd_sel_i(cmd_sel),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_we_o(wbm_we),
        .wbm_sel_o(wbm_sel), .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack), .wbm_dat_i(wbm_dat_i)
    );

    always #5 clk = ~clk;

    // Slave: combinational ack after ack_wait wait states; data bus carries
    // junk except in the ack cycle.
    always @(posedge clk) stb_cnt <= (wbm_cyc && wbm_stb) ? stb_cnt + 1 : 0;
    assign wbm_ack   = force_ack || (wbm_cyc && wbm_stb && !no_ack && stb_cnt == ack_wait);
    assign wbm_dat_i = wbm_ack ? slave_rdata : (32'hBAD0_0000 | stb_cnt);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Handshake monitor: values read at the edge are the pre-edge values.
    always @(posedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra", exp_q.size(), 1);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e[31:0]);
                chk("rsp_err", rsp_err, e[32]);
            end
        end
    end

    // Called at a negedge. Returns at the negedge where rsp_valid is first seen.
    task automatic run_cmd(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                           input logic [31:0] wdata, input int waits, input logic noack,
                           input logic [31:0] rdat, input int exp_cyc,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input logic hold_valid, output int waited);
        int cyc_n, lat;
        logic stable;
        cmd_valid = 1'b1; cmd_we = we; cmd_sel = sel; cmd_addr = addr; cmd_wdata = wdata;
        ack_wait = waits; no_ack = noack; slave_rdata = rdat;
        waited = 0;
        while (!cmd_ready && waited < 100) begin
            @(negedge clk); waited++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", cmd_ready, 1);
            cmd_valid = 1'b0;
            return;
        end
        exp_q.push_back({exp_err, exp_rdata});
        @(negedge clk);
        if (!hold_valid) cmd_valid = 1'b0;
        chk("ready_drop", cmd_ready, 0);
        chk("adr", wbm_adr, BASE | addr);
        chk("we", wbm_we, we);
        chk("sel", wbm_sel, sel);
        chk("dat_o", wbm_dat_o, wdata);
        cyc_n = 0; lat = 1; stable = 1'b1;
        while (!rsp_valid && lat < 400) begin
            if (wbm_cyc) cyc_n++;
            if (wbm_cyc !== wbm_stb || wbm_adr !== (BASE | addr) || wbm_we !== we ||
                wbm_sel !== sel || wbm_dat_o !== wdata) stable = 1'b0;
            @(negedge clk); lat++;
        end
        chk("rsp_seen", rsp_valid, 1);
        chk("latency", lat, exp_cyc + 3);
        chk("cyc_len", cyc_n, exp_cyc);
        chk("bus_stable", stable, 1);
        chk("cyc_idle", wbm_cyc, 0);
    endtask

    initial begin
        int w;
        // Reset
        repeat (2) @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_cyc", wbm_cyc, 0);
        chk("rst_stb", wbm_stb, 0);
        chk("rst_we", wbm_we, 0);
        chk("rst_sel", wbm_sel, 0);
        chk("rst_adr", wbm_adr, 0);
        chk("rst_dat", wbm_dat_o, 0);
        chk("rst_rvalid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait write
        run_cmd(1'b1, 4'hF, 32'h10, 32'hA5A5_0001, 0, 1'b0, 32'hFFFF_FFFF, 1, 32'h0, 1'b0, 1'b0, w);
        @(negedge clk);
        chk("ready_back", cmd_ready, 1);

        // Read with 5 wait states
        run_cmd(1'b0, 4'hF, 32'h4, 32'h0, 5, 1'b0, 32'h1234_5678, 6, 32'h1234_5678, 1'b0, 1'b0, w);

        // Assorted reads/writes
        for (int i = 0; i < 6; i++) begin
            logic        we;
            logic [31:0] d;
            int          ws;
            we = i[0];
            d  = $urandom;
            ws = $urandom_range(0, 4);
            run_cmd(we, 4'(i + 1), 32'(i * 8), ~d, ws, 1'b0, d, ws + 1,
                    we ? 32'h0 : d, 1'b0, 1'b0, w);
        end

        // ack while idle has no effect
        @(negedge clk);
        force_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_ack_rvalid", rsp_valid, 0);
            chk("idle_ack_cyc", wbm_cyc, 0);
            chk("idle_ack_ready", cmd_ready, 1);
        end
        force_ack = 1'b0;

        // Back-pressure: response held, new command waits for handshake
        rsp_ready = 1'b0;
        run_cmd(1'b0, 4'h3, 32'h20, 32'h0, 1, 1'b0, 32'hCAFE_0020, 2, 32'hCAFE_0020, 1'b0, 1'b1, w);
        cmd_we = 1'b1; cmd_addr = 32'h24; cmd_wdata = 32'h0000_0024;
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_rdata", rsp_rdata, 32'hCAFE_0020);
            chk("bp_ready", cmd_ready, 0);
            chk("bp_cyc", wbm_cyc, 0);
        end
        rsp_ready = 1'b1;
        run_cmd(1'b1, 4'hC, 32'h24, 32'h0000_0024, 0, 1'b0, 32'h0, 1, 32'h0, 1'b0, 1'b0, w);
        chk("bp_accept_wait", w, 1);

`ifdef WB_TIMEOUT_EN
        // No ack: abort after 16 cyc cycles
        run_cmd(1'b0, 4'hF, 32'h30, 32'h0, 0, 1'b1, 32'h0, 16, 32'hDEAD_BEEF, 1'b1, 1'b0, w);
        // Ack on the 16th cycle: normal response
        run_cmd(1'b0, 4'hF, 32'h34, 32'h0, 15, 1'b0, 32'h5555_AAAA, 16, 32'h5555_AAAA, 1'b0, 1'b0, w);
`endif

        // Reset pulse during BUS
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_addr = 32'h40; no_ack = 1'b1;
        chk("rstp_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rstp_cyc_up", wbm_cyc, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstp_cyc_drop", wbm_cyc, 0);
        chk("rstp_stb_drop", wbm_stb, 0);
        @(negedge clk);
        rst_n = 1'b1;
        no_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("rstp_no_rsp", rsp_valid, 0);
            chk("rstp_ready_back", cmd_ready, 1);
        end

        chk("sb_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
